// File: rtl/tqvp_reg_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// tqvp_reg_bus_arbiter_if
// Bundles the two-requester request side and the shared TinyQV peripheral
// register port of tqvp_reg_bus_arbiter.
//
// Parameters: ADDR_W register address width, DATA_W register data width.
//
// Requester side : req, req_we, req_txn, req_addr, req_wdata  (into arbiter)
//                  gnt, done, err, rdata, busy                (out of arbiter)
// Peripheral side: address, data_in, data_write_n, data_read_n (out of arbiter)
//                  data_out, data_ready                        (into arbiter)
//
// Modports: slave  - the arbiter itself.
//           master - the environment (requesters plus peripheral).
// -----------------------------------------------------------------------------
interface tqvp_reg_bus_arbiter_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);
   logic [1:0]          req;
   logic [1:0]          req_we;
   logic [3:0]          req_txn;
   logic [2*ADDR_W-1:0] req_addr;
   logic [2*DATA_W-1:0] req_wdata;
   logic [1:0]          gnt;
   logic [1:0]          done;
   logic                err;
   logic [DATA_W-1:0]   rdata;
   logic                busy;
   logic [ADDR_W-1:0]   address;
   logic [DATA_W-1:0]   data_in;
   logic [1:0]          data_write_n;
   logic [1:0]          data_read_n;
   logic [DATA_W-1:0]   data_out;
   logic                data_ready;

   modport slave (
      input  req, req_we, req_txn, req_addr, req_wdata, data_out, data_ready,
      output gnt, done, err, rdata, busy, address, data_in, data_write_n, data_read_n
   );

   modport master (
      output req, req_we, req_txn, req_addr, req_wdata, data_out, data_ready,
      input  gnt, done, err, rdata, busy, address, data_in, data_write_n, data_read_n
   );
endinterface

// File: rtl/tqvp_reg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tqvp_reg_bus_arbiter
// Shares one TinyQV peripheral register port between requester 0 (SPI register
// bridge) and requester 1 (internal sequencer). Round-robin arbitration, one
// transaction in flight, all outputs registered.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset; aborts any transaction in flight
//   bus  - tqvp_reg_bus_arbiter_if.slave (requester handshake + peripheral port)
//
// Optional feature macro: TQVP_ARB_TIMEOUT_EN
//   When defined, a read waiting TIMEOUT_CYCLES cycles without data_ready is
//   abandoned with rdata = all ones and err = 1.
// -----------------------------------------------------------------------------
module tqvp_reg_bus_arbiter #(
   parameter int ADDR_W         = 6,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   tqvp_reg_bus_arbiter_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READ  = 3'd2,
      ST_ERR   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t              state_r, state_s;
   logic                owner_r, owner_s;
   logic                last_r, last_s;
   logic [1:0]          txn_r, txn_s;
   logic [ADDR_W-1:0]   addr_r, addr_s;
   logic [DATA_W-1:0]   wdata_r, wdata_s;
   logic [1:0]          gnt_r, gnt_s;
   logic [1:0]          done_r, done_s;
   logic                err_r, err_s;
   logic [DATA_W-1:0]   rdata_r, rdata_s;
   logic                busy_r, busy_s;
   logic [1:0]          wn_r, wn_s;
   logic [1:0]          rn_r, rn_s;
   logic                pick_s;
   logic [1:0]          sel_txn_s;
   logic                sel_we_s;

`ifdef TQVP_ARB_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
   logic [15:0]         wait_cnt_r, wait_cnt_s;
`endif

   // Zero the bytes above the transfer width; an invalid code yields zero.
   function automatic logic [DATA_W-1:0] mask_rdata(input logic [1:0] txn,
                                                    input logic [DATA_W-1:0] d);
      logic [DATA_W-1:0] m;
      m = {DATA_W{1'b0}};
      case (txn)
         2'b00:   m[7:0]  = d[7:0];
         2'b01:   m[15:0] = d[15:0];
         2'b10:   m       = d;
         default: m       = {DATA_W{1'b0}};
      endcase
      return m;
   endfunction

   // Next-state and next-output logic; every output register is fed from here.
   always_comb begin
      state_s   = state_r;
      owner_s   = owner_r;
      last_s    = last_r;
      txn_s     = txn_r;
      addr_s    = addr_r;
      wdata_s   = wdata_r;
      gnt_s     = gnt_r;
      done_s    = 2'b00;
      err_s     = err_r;
      rdata_s   = rdata_r;
      wn_s      = 2'b11;
      rn_s      = 2'b11;
      pick_s    = 1'b0;
      sel_txn_s = 2'b00;
      sel_we_s  = 1'b0;
`ifdef TQVP_ARB_TIMEOUT_EN
      wait_cnt_s = wait_cnt_r;
`endif
      case (state_r)
         ST_IDLE: begin
            // On a tie the requester that did not win last time gets the port.
            case (bus.req)
               2'b01:   pick_s = 1'b0;
               2'b10:   pick_s = 1'b1;
               2'b11:   pick_s = ~last_r;
               default: pick_s = 1'b0;
            endcase
            sel_txn_s = pick_s ? bus.req_txn[3:2] : bus.req_txn[1:0];
            sel_we_s  = pick_s ? bus.req_we[1]    : bus.req_we[0];
            if (bus.req != 2'b00) begin
               owner_s = pick_s;
               txn_s   = sel_txn_s;
               addr_s  = pick_s ? bus.req_addr[2*ADDR_W-1:ADDR_W]  : bus.req_addr[ADDR_W-1:0];
               wdata_s = pick_s ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
               gnt_s   = pick_s ? 2'b10 : 2'b01;
               if (sel_txn_s == 2'b11) begin
                  state_s = ST_ERR;
               end else if (sel_we_s) begin
                  state_s = ST_WRITE;
                  wn_s    = sel_txn_s;
               end else begin
                  state_s = ST_READ;
                  rn_s    = sel_txn_s;
`ifdef TQVP_ARB_TIMEOUT_EN
                  wait_cnt_s = 16'd0;
`endif
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WRITE: begin
            done_s  = gnt_r;
            err_s   = 1'b0;
            state_s = ST_DONE;
         end
         ST_READ: begin
            // data_ready beats a simultaneous timeout.
            if (bus.data_ready) begin
               rdata_s = mask_rdata(txn_r, bus.data_out);
               err_s   = 1'b0;
               done_s  = gnt_r;
               state_s = ST_DONE;
            end
`ifdef TQVP_ARB_TIMEOUT_EN
            else if (wait_cnt_r + 16'd1 == TIMEOUT_LIM) begin
               rdata_s = {DATA_W{1'b1}};
               err_s   = 1'b1;
               done_s  = gnt_r;
               state_s = ST_DONE;
            end else begin
               wait_cnt_s = wait_cnt_r + 16'd1;
               rn_s       = txn_r;
            end
`else
            else begin
               rn_s = txn_r;
            end
`endif
         end
         ST_ERR: begin
            err_s   = 1'b1;
            done_s  = gnt_r;
            state_s = ST_DONE;
         end
         ST_DONE: begin
            last_s  = owner_r;
            gnt_s   = 2'b00;
            state_s = ST_IDLE;
         end
         default: begin
            gnt_s   = 2'b00;
            state_s = ST_IDLE;
         end
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   // State and output registers; reset aborts immediately and idles the strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         owner_r <= 1'b0;
         last_r  <= 1'b1;
         txn_r   <= 2'b00;
         addr_r  <= {ADDR_W{1'b0}};
         wdata_r <= {DATA_W{1'b0}};
         gnt_r   <= 2'b00;
         done_r  <= 2'b00;
         err_r   <= 1'b0;
         rdata_r <= {DATA_W{1'b0}};
         busy_r  <= 1'b0;
         wn_r    <= 2'b11;
         rn_r    <= 2'b11;
`ifdef TQVP_ARB_TIMEOUT_EN
         wait_cnt_r <= 16'd0;
`endif
      end else begin
         state_r <= state_s;
         owner_r <= owner_s;
         last_r  <= last_s;
         txn_r   <= txn_s;
         addr_r  <= addr_s;
         wdata_r <= wdata_s;
         gnt_r   <= gnt_s;
         done_r  <= done_s;
         err_r   <= err_s;
         rdata_r <= rdata_s;
         busy_r  <= busy_s;
         wn_r    <= wn_s;
         rn_r    <= rn_s;
`ifdef TQVP_ARB_TIMEOUT_EN
         wait_cnt_r <= wait_cnt_s;
`endif
      end
   end

   assign bus.gnt          = gnt_r;
   assign bus.done         = done_r;
   assign bus.err          = err_r;
   assign bus.rdata        = rdata_r;
   assign bus.busy         = busy_r;
   assign bus.address      = addr_r;
   assign bus.data_in      = wdata_r;
   assign bus.data_write_n = wn_r;
   assign bus.data_read_n  = rn_r;

endmodule

// File: tb/tb_tqvp_reg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tqvp_reg_bus_arbiter
// Self-checking bench: expected done/err/rdata are queued when a request is
// driven and popped by a monitor on every done pulse; scenario tasks also check
// strobe timing inline.
// -----------------------------------------------------------------------------
module tb_tqvp_reg_bus_arbiter;
   localparam int ADDR_W         = 6;
   localparam int DATA_W         = 32;
   localparam int TIMEOUT_CYCLES = 4;

   typedef struct packed {
      logic [1:0]  done;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   int    checks = 0;
   int    errors = 0;
   exp_t  exp_q[$];
   exp_t  mon_e;
   logic [31:0] model_rdata = 32'h0;

   always #5 clk = ~clk;

   tqvp_reg_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

   tqvp_reg_bus_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Monitor: strobe exclusivity every cycle, done pulses against the queue.
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if (bus.data_write_n !== 2'b11 && bus.data_read_n !== 2'b11) begin
            errors++;
            $display("FAIL strobe_overlap write_n=%b read_n=%b both active", bus.data_write_n, bus.data_read_n);
         end
         if (bus.done !== 2'b00) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done got=%b expected no done", bus.done);
            end else begin
               mon_e = exp_q.pop_front();
               if (bus.done !== mon_e.done || bus.err !== mon_e.err || bus.rdata !== mon_e.rdata) begin
                  errors++;
                  $display("FAIL scoreboard got done=%b err=%b rdata=%h expected done=%b err=%b rdata=%h",
                           bus.done, bus.err, bus.rdata, mon_e.done, mon_e.err, mon_e.rdata);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req        = 2'b00;
      bus.req_we     = 2'b00;
      bus.req_txn    = 4'b0000;
      bus.req_addr   = {2*ADDR_W{1'b0}};
      bus.req_wdata  = {2*DATA_W{1'b0}};
      bus.data_out   = 32'h0;
      bus.data_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.gnt, bus.done, bus.err, bus.busy} !== 6'b000000) begin
         errors++;
         $display("FAIL reset_ctrl got gnt=%b done=%b err=%b busy=%b expected 00 00 0 0", bus.gnt, bus.done, bus.err, bus.busy);
      end
      checks++;
      if (bus.data_write_n !== 2'b11 || bus.data_read_n !== 2'b11) begin
         errors++;
         $display("FAIL reset_strobes got write_n=%b read_n=%b expected 11 11", bus.data_write_n, bus.data_read_n);
      end
      checks++;
      if (bus.rdata !== 32'h0 || bus.address !== 6'h00 || bus.data_in !== 32'h0) begin
         errors++;
         $display("FAIL reset_data got rdata=%h address=%h data_in=%h expected 0 0 0", bus.rdata, bus.address, bus.data_in);
      end
      step();
      rst = 1'b0;
      model_rdata = 32'h0;
   endtask

   task automatic test_write_word();
      step();
      bus.req = 2'b01; bus.req_we = 2'b01; bus.req_txn = 4'b0010;
      bus.req_addr = {6'h00, 6'h05}; bus.req_wdata = {32'h0, 32'hDEADBEEF};
      exp_q.push_back('{done: 2'b01, err: 1'b0, rdata: model_rdata});
      @(negedge clk);
      step();
      // Inputs change after the grant; the latched copy must be used.
      bus.req = 2'b00; bus.req_txn = 4'b0000; bus.req_addr = {6'h00, 6'h3F}; bus.req_wdata = 64'h0;
      @(negedge clk);
      checks++;
      if (bus.data_write_n !== 2'b10 || bus.address !== 6'h05 || bus.data_in !== 32'hDEADBEEF || bus.gnt !== 2'b01) begin
         errors++;
         $display("FAIL write_strobe got write_n=%b addr=%h data_in=%h gnt=%b expected 10 05 deadbeef 01",
                  bus.data_write_n, bus.address, bus.data_in, bus.gnt);
      end
      step();
      @(negedge clk);
      checks++;
      if (bus.done !== 2'b01 || bus.data_write_n !== 2'b11) begin
         errors++;
         $display("FAIL write_done got done=%b write_n=%b expected 01 11", bus.done, bus.data_write_n);
      end
      step();
      @(negedge clk);
      checks++;
      if (bus.gnt !== 2'b00 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL write_release got gnt=%b busy=%b expected 00 0", bus.gnt, bus.busy);
      end
   endtask

   task automatic test_read_byte_wait();
      step();
      bus.req = 2'b10; bus.req_we = 2'b00; bus.req_txn = 4'b0000;
      bus.req_addr = {6'h12, 6'h00}; bus.data_out = 32'h12345678; bus.data_ready = 1'b0;
      exp_q.push_back('{done: 2'b10, err: 1'b0, rdata: 32'h00000078});
      model_rdata = 32'h00000078;
      @(negedge clk);
      for (int c = 1; c <= 4; c++) begin
         step();
         if (c == 1) begin
            bus.req = 2'b00; bus.req_addr = {6'h3F, 6'h00};
         end
         if (c == 4) bus.data_ready = 1'b1;
         @(negedge clk);
         checks++;
         if (bus.data_read_n !== 2'b00 || bus.address !== 6'h12 || bus.done !== 2'b00) begin
            errors++;
            $display("FAIL read_hold cycle=%0d got read_n=%b addr=%h done=%b expected 00 12 00",
                     c, bus.data_read_n, bus.address, bus.done);
         end
      end
      step();
      bus.data_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.done !== 2'b10 || bus.rdata !== 32'h00000078 || bus.data_read_n !== 2'b11) begin
         errors++;
         $display("FAIL read_done got done=%b rdata=%h read_n=%b expected 10 00000078 11",
                  bus.done, bus.rdata, bus.data_read_n);
      end
      step();
   endtask

   task automatic test_invalid_txn();
      step();
      bus.req = 2'b01; bus.req_we = 2'b01; bus.req_txn = 4'b0011; bus.req_addr = {6'h00, 6'h09};
      exp_q.push_back('{done: 2'b01, err: 1'b1, rdata: model_rdata});
      @(negedge clk);
      step();
      bus.req = 2'b00;
      @(negedge clk);
      checks++;
      if (bus.data_write_n !== 2'b11 || bus.data_read_n !== 2'b11 || bus.gnt !== 2'b01) begin
         errors++;
         $display("FAIL invalid_nostrobe got write_n=%b read_n=%b gnt=%b expected 11 11 01",
                  bus.data_write_n, bus.data_read_n, bus.gnt);
      end
      step();
      @(negedge clk);
      checks++;
      if (bus.done !== 2'b01 || bus.err !== 1'b1 || bus.rdata !== model_rdata) begin
         errors++;
         $display("FAIL invalid_done got done=%b err=%b rdata=%h expected 01 1 %h", bus.done, bus.err, bus.rdata, model_rdata);
      end
      step();
   endtask

   task automatic test_reset_mid_read();
      step();
      bus.req = 2'b01; bus.req_we = 2'b00; bus.req_txn = 4'b0010; bus.req_addr = {6'h00, 6'h07};
      bus.data_ready = 1'b0;
      @(negedge clk);
      step();
      bus.req = 2'b00;
      @(negedge clk);
      checks++;
      if (bus.data_read_n !== 2'b10) begin
         errors++;
         $display("FAIL midread_strobe got read_n=%b expected 10", bus.data_read_n);
      end
      step();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.data_read_n !== 2'b11 || bus.gnt !== 2'b00 || bus.busy !== 1'b0 || bus.done !== 2'b00) begin
         errors++;
         $display("FAIL midread_abort got read_n=%b gnt=%b busy=%b done=%b expected 11 00 0 00",
                  bus.data_read_n, bus.gnt, bus.busy, bus.done);
      end
      repeat (2) @(posedge clk);
      step();
      rst = 1'b0;
      model_rdata = 32'h0;
      // Both request at once: the reset pointer must favour requester 0.
      bus.req = 2'b11; bus.req_we = 2'b11; bus.req_txn = 4'b1010;
      bus.req_addr = {6'h21, 6'h11}; bus.req_wdata = {32'h11111111, 32'h22222222};
      exp_q.push_back('{done: 2'b01, err: 1'b0, rdata: 32'h0});
      @(negedge clk);
      step();
      bus.req = 2'b00;
      @(negedge clk);
      checks++;
      if (bus.gnt !== 2'b01 || bus.address !== 6'h11 || bus.data_in !== 32'h22222222) begin
         errors++;
         $display("FAIL post_reset_grant got gnt=%b addr=%h data_in=%h expected 01 11 22222222",
                  bus.gnt, bus.address, bus.data_in);
      end
      repeat (2) begin
         step();
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_seq [4];
      logic [1:0] prev_gnt;
      int ngr;
      int last_cyc;
      exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
      prev_gnt = 2'b00; ngr = 0; last_cyc = 0;
      step();
      rst = 1'b1;
      idle_inputs();
      step();
      rst = 1'b0;
      model_rdata = 32'h0;
      bus.req = 2'b11; bus.req_we = 2'b01; bus.req_txn = 4'b0110;
      bus.req_addr = {6'h2A, 6'h15}; bus.req_wdata = {32'h0, 32'hA5A5A5A5};
      bus.data_out = 32'hCAFEF00D; bus.data_ready = 1'b1;
      exp_q.push_back('{done: 2'b01, err: 1'b0, rdata: 32'h0});
      exp_q.push_back('{done: 2'b10, err: 1'b0, rdata: 32'h0000F00D});
      exp_q.push_back('{done: 2'b01, err: 1'b0, rdata: 32'h0000F00D});
      exp_q.push_back('{done: 2'b10, err: 1'b0, rdata: 32'h0000F00D});
      for (int c = 0; c < 40 && ngr < 4; c++) begin
         @(negedge clk);
         if (bus.gnt !== 2'b00 && prev_gnt === 2'b00) begin
            checks++;
            if (bus.gnt !== exp_seq[ngr]) begin
               errors++;
               $display("FAIL b2b_grant idx=%0d got gnt=%b expected %b", ngr, bus.gnt, exp_seq[ngr]);
            end
            if (ngr > 0) begin
               checks++;
               if (c - last_cyc != 3) begin
                  errors++;
                  $display("FAIL b2b_spacing idx=%0d got %0d cycles expected 3", ngr, c - last_cyc);
               end
            end
            last_cyc = c;
            ngr++;
         end
         prev_gnt = bus.gnt;
      end
      step();
      bus.req = 2'b00;
      bus.data_ready = 1'b0;
      checks++;
      if (ngr != 4) begin
         errors++;
         $display("FAIL b2b_timeout got %0d grants expected 4", ngr);
      end
      repeat (3) begin
         step();
         @(negedge clk);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_pending got %0d outstanding expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

`ifdef TQVP_ARB_TIMEOUT_EN
   task automatic test_read_timeout();
      int found;
      found = -1;
      step();
      bus.req = 2'b10; bus.req_we = 2'b00; bus.req_txn = 4'b1000; bus.req_addr = {6'h30, 6'h00};
      bus.data_ready = 1'b0;
      exp_q.push_back('{done: 2'b10, err: 1'b1, rdata: 32'hFFFFFFFF});
      model_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      step();
      bus.req = 2'b00;
      for (int c = 1; c < 30 && found < 0; c++) begin
         if (c > 1) step();
         @(negedge clk);
         if (bus.done !== 2'b00) found = c;
      end
      checks++;
      if (found != TIMEOUT_CYCLES + 1) begin
         errors++;
         $display("FAIL timeout_latency got done at cycle %0d expected %0d", found, TIMEOUT_CYCLES + 1);
      end
      step();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_word();
      test_read_byte_wait();
      test_invalid_txn();
      test_reset_mid_read();
      test_back_to_back();
`ifdef TQVP_ARB_TIMEOUT_EN
      test_read_timeout();
`endif
      repeat (2) step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_done got %0d outstanding expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/tqvp_reg_bus_arbiter.md
Name: tqvp_reg_bus_arbiter

Overview:
- Shares one TinyQV peripheral register port (address, data_in, data_write_n, data_read_n, data_out, data_ready) between two requesters.
- Requester 0 is the SPI register bridge; requester 1 is an internal sequencer, e.g. a SLAM autoscan engine.
- Round-robin arbitration, one transaction in flight, registered downstream strobes.
- Byte/half/word read-data masking follows the txn width code.

Parameters:
- ADDR_W, 6, register address width.
- DATA_W, 32, register data width.
- TIMEOUT_CYCLES, 255, maximum read wait in cycles; used only when TQVP_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  2  request per requester, level; bit i belongs to requester i.
- req_we  in  2  1 = write, 0 = read, per requester.
- req_txn  in  4  {txn1,txn0}: 00 byte, 01 half, 10 word, 11 invalid.
- req_addr  in  2*ADDR_W  {addr1,addr0}.
- req_wdata  in  2*DATA_W  {wdata1,wdata0}.
- gnt  out  2  one-hot owner; high from the accept cycle through the done cycle.
- done  out  2  one-cycle completion pulse to the owner.
- err  out  1  valid with done: invalid txn or timeout.
- rdata  out  DATA_W  masked read data; valid with done, held until the next done.
- busy  out  1  high whenever state != IDLE.
- address  out  ADDR_W  to peripheral.
- data_in  out  DATA_W  write data to peripheral.
- data_write_n  out  2  11 = idle, else write width.
- data_read_n  out  2  11 = idle, else read width.
- data_out  in  DATA_W  peripheral read data.
- data_ready  in  1  peripheral read-data-valid.

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-high.
- Reset values: state IDLE, gnt 00, done 00, err 0, rdata 0, busy 0, address 0, data_in 0, data_write_n 11, data_read_n 11, last-granted pointer = 1 (so requester 0 wins the first tie).
- Reset mid-transaction: abort immediately. No done is issued, and strobes return to 11 asynchronously.
- IDLE:
  - Sample req. With one requester active, grant it. With both active, grant the one != last-granted.
  - On grant, register that requester's addr, wdata, txn and we, set gnt one-hot, and move on the next edge.
  - Destination: WRITE if we=1 and txn != 11; READ if we=0 and txn != 11; ERR if txn = 11.
- WRITE: data_write_n = latched txn for exactly one cycle, address/data_in driven from latches, then DONE.
- READ:
  - data_read_n = latched txn, held every cycle until data_ready is sampled high (data_ready may be high in the first READ cycle).
  - On data_ready, capture data_out into rdata with masking: txn 00 → bits[31:8] = 0; txn 01 → bits[31:16] = 0; txn 10 → unmasked. Then go to DONE.
- ERR: no downstream strobe; rdata unchanged; go to DONE with err = 1.
- DONE:
  - Drive done[owner] = 1 for one cycle, with err valid alongside it.
  - Update last-granted = owner, clear gnt on the next edge, return to IDLE.
  - IDLE re-samples req on the following cycle, so a requester still holding req after done starts a new transaction.
- Latency (req high at cycle 0, arbiter idle):
  - Write: strobe in cycle 1, done in cycle 2.
  - Read with data_ready in the strobe cycle: done in cycle 2. Each extra cycle of waiting for data_ready adds one cycle.
- Requester inputs may change after gnt; the latched copy is used throughout.
- Back-to-back with both requesters asserting continuously: grants alternate 0,1,0,1. Minimum spacing between accepted transactions is 3 cycles.
- data_write_n and data_read_n are never both != 11 in the same cycle.
- data_ready outside READ is ignored.

Optional Feature:
- Macro: TQVP_ARB_TIMEOUT_EN.
- With the macro defined:
  - An 8..16-bit wait counter clears on READ entry and increments each READ cycle without data_ready.
  - When the counter reaches TIMEOUT_CYCLES, the read is abandoned: data_read_n returns to 11, rdata = all ones, err = 1 at done.
  - data_ready in the same cycle as the counter reaching its limit wins: a normal read, err = 0.
- Without the macro: READ waits indefinitely, err is set only for txn 11, and no counter logic is present.

Test Plan:
- Requester 0 writes word 0xDEADBEEF to addr 0x05, txn 10 → one cycle with data_write_n = 10, address = 05, data_in = DEADBEEF; done = 01 two cycles after req; err = 0.
- Requester 1 reads byte, txn 00, from addr 0x12; peripheral returns data_out 0x12345678 with data_ready after a 3-cycle wait → data_read_n = 00 held 4 cycles; rdata = 0x00000078; done = 10.
- Both requesters assert continuously from reset → gnt sequence 01, 10, 01, 10; no overlap of strobes; done pulses alternate.
- Requester 0 issues txn 11 → no strobe, done = 01 with err = 1, rdata unchanged.
- rst asserted mid-READ → data_read_n = 11, gnt = 00, busy = 0 immediately; no done pulse; next request after release is granted to requester 0.
- With TQVP_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 4, read with data_ready held low → done after the timeout; err = 1, rdata = 0xFFFFFFFF.
